// File: rtl/mips_multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// Optional addi support is enabled with MIPS_CTRL_ADDI_EN (see the top module).
package mips_ctrl_pkg;

    localparam int ALU_CON_WIDTH = 3;
    localparam int OP_WIDTH      = 6;
    localparam int FUNCT_WIDTH   = 6;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_e;

    localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_WIDTH-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_WIDTH-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_WIDTH-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLT = 6'b101010;

    localparam logic [ALU_CON_WIDTH-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CON_WIDTH-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CON_WIDTH-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CON_WIDTH-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CON_WIDTH-1:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle; ctrl drives the control lines,
// dp supplies instruction fields, zero flag and memory ready.
interface mips_ctrl_if;
    import mips_ctrl_pkg::*;

    logic [OP_WIDTH-1:0]      op;
    logic [FUNCT_WIDTH-1:0]   funct;
    logic                     zero_flag;
    logic                     mem_ready;
    logic                     mem_req;
    logic                     iord;
    logic                     mem_wr;
    logic                     ir_wr;
    logic                     pc_en;
    logic                     reg_wr;
    logic                     reg_dst;
    logic                     mem_to_reg;
    logic                     alu_src_a;
    logic [1:0]               alu_src_b;
    logic [1:0]               pc_src;
    logic [ALU_CON_WIDTH-1:0] alu_con;
    logic                     illegal_op;
    logic                     instr_done;

    modport ctrl (
        input  op, funct, zero_flag, mem_ready,
        output mem_req, iord, mem_wr, ir_wr, pc_en, reg_wr, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, alu_con, illegal_op, instr_done
    );

    modport dp (
        output op, funct, zero_flag, mem_ready,
        input  mem_req, iord, mem_wr, ir_wr, pc_en, reg_wr, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, alu_con, illegal_op, instr_done
    );

endinterface

// File: rtl/mips_multicycle_controller_alu_dec.sv
// ALU control decode: aluop/funct to alu_con, plus whether funct is a supported R-type.
module alu_decoder_mips
    import mips_ctrl_pkg::*;
(
    input  aluop_e                   aluop_i,
    input  logic [FUNCT_WIDTH-1:0]   funct_i,
    output logic [ALU_CON_WIDTH-1:0] alu_con_o,
    output logic                     funct_valid_o
);

    logic [ALU_CON_WIDTH-1:0] funct_con;

    always_comb begin
        funct_valid_o = 1'b1;
        funct_con     = ALU_ADD;
        case (funct_i)
            FUNCT_ADD: funct_con = ALU_ADD;
            FUNCT_SUB: funct_con = ALU_SUB;
            FUNCT_AND: funct_con = ALU_AND;
            FUNCT_OR:  funct_con = ALU_OR;
            FUNCT_SLT: funct_con = ALU_SLT;
            default:   funct_valid_o = 1'b0;
        endcase

        case (aluop_i)
            ALUOP_ADD:   alu_con_o = ALU_ADD;
            ALUOP_SUB:   alu_con_o = ALU_SUB;
            ALUOP_FUNCT: alu_con_o = funct_con;
            default:     alu_con_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS controller: Moore FSM sequencing a shared ALU/memory datapath.
// Define MIPS_CTRL_ADDI_EN to decode addi (ADDIEX/ADDIWB); otherwise addi is illegal.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 on mem_ready
// DECODE | compute branch target, dispatch on op
// MEMADR | base + offset for lw/sw
// MEMRD  | load access, wait for mem_ready
// MEMWB  | load data into rt
// MEMWR  | store access, strobe held until mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | ALU result into rd
// BRANCH | beq compare, conditional PC load
// ADDIEX | rs + immediate
// ADDIWB | result into rt
// JUMP   | PC <- jump target
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mips_ctrl_if.ctrl   bus
);

    state_e                   state_q, state_d;
    aluop_e                   aluop;
    logic                     funct_valid;
    logic [ALU_CON_WIDTH-1:0] dec_con;
    logic                     alu_use;
    logic                     pc_wr, branch;
    logic                     mem_req, iord, mem_wr, ir_wr;
    logic                     reg_wr, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]               alu_src_b, pc_src;
    logic                     illegal_op, instr_done;

    alu_decoder_mips u_alu_dec (
        .aluop_i       (aluop),
        .funct_i       (bus.funct),
        .alu_con_o     (dec_con),
        .funct_valid_o (funct_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        aluop      = ALUOP_ADD;
        alu_use    = 1'b0;
        pc_wr      = 1'b0;
        branch     = 1'b0;
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        pc_src     = PCSRC_ALU;
        illegal_op = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_use   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_wr     = bus.mem_ready;
                pc_wr     = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_use   = 1'b1;
                alu_src_b = SRCB_IMM_SH;
                state_d   = S_FETCH;
                case (bus.op)
                    OP_RTYPE: begin
                        if (funct_valid) state_d = S_EXEC;
                        else             illegal_op = 1'b1;
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    OP_J:         state_d = S_JUMP;
                    default:      illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_use   = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_wr  = 1'b1;
                if (bus.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_use   = 1'b1;
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr     = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_use    = 1'b1;
                alu_src_a  = 1'b1;
                aluop      = ALUOP_SUB;
                pc_src     = PCSRC_ALUOUT;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_use   = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_wr     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_wr      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Every output is gated by rst so an aborted access drops its strobes at once.
    assign bus.mem_req    = rst & mem_req;
    assign bus.iord       = rst & iord;
    assign bus.mem_wr     = rst & mem_wr;
    assign bus.ir_wr      = rst & ir_wr;
    assign bus.pc_en      = rst & (pc_wr | (branch & bus.zero_flag));
    assign bus.reg_wr     = rst & reg_wr;
    assign bus.reg_dst    = rst & reg_dst;
    assign bus.mem_to_reg = rst & mem_to_reg;
    assign bus.alu_src_a  = rst & alu_src_a;
    assign bus.alu_src_b  = rst ? alu_src_b : 2'b00;
    assign bus.pc_src     = rst ? pc_src : 2'b00;
    assign bus.alu_con    = (rst && alu_use) ? dec_con : '0;
    assign bus.illegal_op = rst & illegal_op;
    assign bus.instr_done = rst & instr_done;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomized bench: per-instruction expected output sequence built from the
// instruction-class rules, compared with the controller outputs every cycle.
module tb_mips_multicycle_controller;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_wr;
        logic       ir_wr;
        logic       pc_en;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_con;
        logic       illegal_op;
        logic       instr_done;
    } out_t;

    typedef struct {
        out_t o;
        logic mr;
        logic zf;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mips_ctrl_if bus();
    mips_multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

    step_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    localparam int C_ILL = 0, C_R = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_ADDI = 5, C_J = 6;

    function automatic out_t sample();
        out_t s;
        s.mem_req    = bus.mem_req;
        s.iord       = bus.iord;
        s.mem_wr     = bus.mem_wr;
        s.ir_wr      = bus.ir_wr;
        s.pc_en      = bus.pc_en;
        s.reg_wr     = bus.reg_wr;
        s.reg_dst    = bus.reg_dst;
        s.mem_to_reg = bus.mem_to_reg;
        s.alu_src_a  = bus.alu_src_a;
        s.alu_src_b  = bus.alu_src_b;
        s.pc_src     = bus.pc_src;
        s.alu_con    = bus.alu_con;
        s.illegal_op = bus.illegal_op;
        s.instr_done = bus.instr_done;
        return s;
    endfunction

    function automatic int rcon(logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return -1;
        endcase
    endfunction

    function automatic int classify(logic [5:0] op, logic [5:0] f);
        case (op)
            6'b000000: return (rcon(f) < 0) ? C_ILL : C_R;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
`ifdef MIPS_CTRL_ADDI_EN
            6'b001000: return C_ADDI;
`endif
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    // mr: 0/1 forced memory-ready value, 2 = don't care (randomized)
    function automatic void push(out_t o, int mr, logic zf);
        step_t s;
        s.o  = o;
        s.mr = (mr == 2) ? 1'($urandom_range(0, 1)) : mr[0];
        s.zf = zf;
        exp_q.push_back(s);
    endfunction

    function automatic logic rz();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycles of one instruction given fetch/memory wait counts.
    function automatic void gen(logic [5:0] op, logic [5:0] f, int fw, int mw, logic zf_br);
        out_t o;
        int   cls;
        exp_q.delete();
        for (int i = 0; i <= fw; i++) begin
            o = '0;
            o.mem_req   = 1'b1;
            o.alu_src_b = 2'b01;
            o.alu_con   = 3'b010;
            o.ir_wr     = (i == fw);
            o.pc_en     = (i == fw);
            push(o, (i == fw) ? 1 : 0, rz());
        end
        cls = classify(op, f);
        o = '0;
        o.alu_src_b  = 2'b11;
        o.alu_con    = 3'b010;
        o.illegal_op = (cls == C_ILL);
        push(o, 2, rz());
        if (cls == C_LW || cls == C_SW) begin
            o = '0;
            o.alu_src_a = 1'b1;
            o.alu_src_b = 2'b10;
            o.alu_con   = 3'b010;
            push(o, 2, rz());
            for (int i = 0; i <= mw; i++) begin
                o = '0;
                o.mem_req    = 1'b1;
                o.iord       = 1'b1;
                o.mem_wr     = (cls == C_SW);
                o.instr_done = (cls == C_SW) && (i == mw);
                push(o, (i == mw) ? 1 : 0, rz());
            end
            if (cls == C_LW) begin
                o = '0;
                o.reg_wr     = 1'b1;
                o.mem_to_reg = 1'b1;
                o.instr_done = 1'b1;
                push(o, 2, rz());
            end
        end else if (cls == C_R) begin
            o = '0;
            o.alu_src_a = 1'b1;
            o.alu_con   = 3'(rcon(f));
            push(o, 2, rz());
            o = '0;
            o.reg_wr     = 1'b1;
            o.reg_dst    = 1'b1;
            o.instr_done = 1'b1;
            push(o, 2, rz());
        end else if (cls == C_BEQ) begin
            o = '0;
            o.alu_src_a  = 1'b1;
            o.alu_con    = 3'b110;
            o.pc_src     = 2'b01;
            o.pc_en      = zf_br;
            o.instr_done = 1'b1;
            push(o, 2, zf_br);
        end else if (cls == C_ADDI) begin
            o = '0;
            o.alu_src_a = 1'b1;
            o.alu_src_b = 2'b10;
            o.alu_con   = 3'b010;
            push(o, 2, rz());
            o = '0;
            o.reg_wr     = 1'b1;
            o.instr_done = 1'b1;
            push(o, 2, rz());
        end else if (cls == C_J) begin
            o = '0;
            o.pc_src     = 2'b10;
            o.pc_en      = 1'b1;
            o.instr_done = 1'b1;
            push(o, 2, rz());
        end
    endfunction

    task automatic check_out(string name, out_t act, out_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%05h required=%05h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Entry/exit point: posedge+1. limit < 0 runs the whole queue.
    task automatic run_q(string name, int limit);
        step_t s;
        int    n = 0;
        while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
            s = exp_q.pop_front();
            bus.mem_ready = s.mr;
            bus.zero_flag = s.zf;
            @(negedge clk);
            check_out(name, sample(), s.o);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_instr(string name, logic [5:0] op, logic [5:0] f, int fw, int mw, logic zf);
        bus.op    = op;
        bus.funct = f;
        gen(op, f, fw, mw, zf);
        run_q(name, -1);
    endtask

    logic [5:0] valid_f[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        out_t       zero_o;
        out_t       memwr_o;
        logic [5:0] op, f;
        int         kind;
        zero_o = '0;
        bus.op        = 6'b100011;
        bus.funct     = 6'b000000;
        bus.mem_ready = 1'b1;
        bus.zero_flag = 1'b1;

        #1 check_out("reset_outputs_zero", sample(), zero_o);
        @(posedge clk);
        @(negedge clk);
        check_out("reset_outputs_held", sample(), zero_o);
        @(posedge clk);
        #1 rst = 1'b1;

        // Pin the model cycle counts against hand-computed values.
        gen(6'b000000, 6'b100000, 0, 0, 1'b0); check_int("len_rtype", exp_q.size(), 4);
        gen(6'b100011, 6'b000000, 0, 0, 1'b0); check_int("len_lw",    exp_q.size(), 5);
        gen(6'b100011, 6'b000000, 2, 3, 1'b0); check_int("len_lw_w",  exp_q.size(), 10);
        gen(6'b101011, 6'b000000, 0, 0, 1'b0); check_int("len_sw",    exp_q.size(), 4);
        gen(6'b000100, 6'b000000, 0, 0, 1'b1); check_int("len_beq",   exp_q.size(), 3);
        gen(6'b000010, 6'b000000, 0, 0, 1'b0); check_int("len_j",     exp_q.size(), 3);
        gen(6'b111111, 6'b000000, 0, 0, 1'b0); check_int("len_ill",   exp_q.size(), 2);

        do_instr("rtype_add",   6'b000000, 6'b100000, 0, 0, 1'b0);
        do_instr("lw_waits",    6'b100011, 6'b010101, 2, 3, 1'b0);
        do_instr("beq_taken",   6'b000100, 6'b000000, 0, 0, 1'b1);
        do_instr("beq_not",     6'b000100, 6'b000000, 1, 0, 1'b0);
        do_instr("illegal_op",  6'b111111, 6'b100000, 0, 0, 1'b0);
        do_instr("rtype_badf",  6'b000000, 6'b000001, 0, 0, 1'b0);
        do_instr("addi",        6'b001000, 6'b000000, 0, 0, 1'b0);
        do_instr("sw_waits",    6'b101011, 6'b000000, 1, 2, 1'b0);
        do_instr("jump",        6'b000010, 6'b000000, 0, 0, 1'b0);

        // Reset while a store waits for memory: strobe must drop immediately.
        bus.op    = 6'b101011;
        bus.funct = 6'b000000;
        gen(6'b101011, 6'b000000, 0, 5, 1'b0);
        run_q("sw_pre_reset", 4);
        bus.mem_ready = 1'b0;
        memwr_o = '0;
        memwr_o.mem_req = 1'b1;
        memwr_o.iord    = 1'b1;
        memwr_o.mem_wr  = 1'b1;
        #1 check_out("memwr_before_reset", sample(), memwr_o);
        rst = 1'b0;
        #1 check_out("memwr_reset_drop", sample(), zero_o);
        @(negedge clk);
        check_out("memwr_reset_held", sample(), zero_o);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        do_instr("after_reset", 6'b000000, 6'b100010, 0, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 7);
            f    = 6'($urandom_range(0, 63));
            case (kind)
                0: begin op = 6'b000000; f = valid_f[$urandom_range(0, 4)]; end
                1: begin op = 6'b000000; while (rcon(f) >= 0) f = 6'($urandom_range(0, 63)); end
                2: op = 6'b100011;
                3: op = 6'b101011;
                4: op = 6'b000100;
                5: op = 6'b001000;
                6: op = 6'b000010;
                default: op = 6'($urandom_range(0, 63));
            endcase
            do_instr("random", op, f,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     rz());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
